// File: rtl/z80io_pkg.sv
// Shared definitions for the Z80 I/O-space responder: register offsets,
// STATUS bit positions and the bus-cycle FSM encoding.
package z80io_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int ST_RXNE   = 0;
  localparam int ST_TXNF   = 1;
  localparam int ST_RXOVF  = 2;
  localparam int ST_TXFULL = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACT  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  // Assemble the STATUS byte; upper nibble always reads 0.
  function automatic logic [7:0] pack_status(input logic txfull, input logic rxovf,
                                             input logic txnf, input logic rxne);
    logic [7:0] s;
    s            = 8'h00;
    s[ST_TXFULL] = txfull;
    s[ST_RXOVF]  = rxovf;
    s[ST_TXNF]   = txnf;
    s[ST_RXNE]   = rxne;
    return s;
  endfunction

endpackage

// File: rtl/z80io_fifo.sv
// Byte-wide synchronous FIFO. A push while full is dropped unless a pop
// happens in the same cycle, in which case both take effect.
module z80io_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage, wrapping pointers and occupancy count; memory clears so the
  // head reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/z80_io_responder.sv
// Z80 I/O-space target: decodes IN/OUT cycles at BASE_ADDR..+3, inserts
// wait states, drives DQ on reads and bridges to TX/RX byte FIFOs.
// Optional feature macro: Z80IO_IRQ_EN (registered nINT from CTRL.IE & RXNE).
module z80_io_responder #(
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         WAIT_STATES = 1,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] ADDR,
  inout  wire  [7:0] DQ,
  input  logic       nRD,
  input  logic       nWR,
  input  logic       nIORQ,
  input  logic       nM1,
  output logic       nWAIT,
  output logic       nINT,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY
);

  import z80io_pkg::*;

  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [2:0] WS_INIT  = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

  // Bus decode. Interrupt acknowledge (nM1 low) never matches.
  logic       rd_req, wr_req, hit, rd_hit;
  logic [1:0] off;
  assign rd_req = ~nRD;
  assign wr_req = ~nWR;
  assign hit    = ~nIORQ & nM1 & (rd_req ^ wr_req) & (ADDR[7:2] == BASE_ADDR[7:2]);
  assign rd_hit = hit & rd_req;
  assign off    = ADDR[1:0];

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rxovf_q;
  logic       ie_q;

  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_dout, rx_dout;
  logic       act, act_rd, act_wr, tx_push, rx_pop, ovf_clr, ovf_set;
  logic [7:0] reg_mux;

  // Side effects only happen in the single ACT cycle of an access.
  assign act     = (state_q == S_ACT);
  assign act_rd  = act & rd_req;
  assign act_wr  = act & wr_req;
  assign tx_push = act_wr & (off == OFF_DATA);
  assign rx_pop  = act_rd & (off == OFF_DATA);
  assign ovf_clr = act_rd & (off == OFF_STATUS);
  // A pop on the same edge makes room, so a full FIFO does not overflow then.
  assign ovf_set = RX_VALID & rx_full & ~rx_pop;

  z80io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(CLK), .rst(CLR),
    .push_i(tx_push), .pop_i(TX_READY), .din_i(DQ),
    .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty)
  );

  z80io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(CLK), .rst(CLR),
    .push_i(RX_VALID), .pop_i(rx_pop), .din_i(RX_DATA),
    .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign TX_DATA  = tx_dout;
  assign TX_VALID = ~tx_empty;
  assign RX_READY = ~rx_full;

  // Read-side register mux, live view of the current register contents.
  always_comb begin
    reg_mux = 8'hFF;
    case (off)
      OFF_DATA:   reg_mux = rx_empty ? 8'h00 : rx_dout;
      OFF_STATUS: reg_mux = pack_status(tx_full, rxovf_q, ~tx_full, ~rx_empty);
      OFF_CTRL:   reg_mux = {7'b0, ie_q};
      default:    reg_mux = 8'hFF;
    endcase
  end

  // Access FSM next state; read data is captured on entry to ACT so it is
  // stable on DQ through ACT and HOLD, before the pop takes effect.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (hit) begin
        if (HAS_WAIT) begin
          state_d = S_WAIT;
          cnt_d   = WS_INIT;
        end else begin
          state_d = S_ACT;
        end
      end
      S_WAIT: begin
        if (!hit)              state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_ACT;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      S_ACT:  state_d = S_HOLD;
      S_HOLD: if (!hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rdata_d = ((state_d == S_ACT) && (state_q != S_ACT)) ? reg_mux : rdata_q;
  end

  // FSM, wait counter and captured read data.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Sticky RX overflow; a fresh overflow beats a same-cycle STATUS-read clear.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)          rxovf_q <= 1'b0;
    else if (ovf_set) rxovf_q <= 1'b1;
    else if (ovf_clr) rxovf_q <= 1'b0;
  end

`ifdef Z80IO_IRQ_EN
  logic ctrl_wr, nint_q;
  assign ctrl_wr = act_wr & (off == OFF_CTRL);

  // CTRL.IE, written from DQ[0] in ACT.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)          ie_q <= 1'b0;
    else if (ctrl_wr) ie_q <= DQ[0];
  end

  // Registered interrupt request: level while enabled and RX holds data.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) nint_q <= 1'b1;
    else     nint_q <= ~(ie_q & ~rx_empty);
  end
  assign nINT = nint_q;
`else
  assign ie_q = 1'b0;
  assign nINT = 1'b1;
`endif

  // Bus outputs are forced inactive while CLR is held so a reset mid-access
  // releases the CPU immediately even though the strobes are still low.
  logic       wait_req, dq_oe;
  logic [7:0] dq_out;
  assign wait_req = ((state_q == S_IDLE) & hit & HAS_WAIT) | (state_q == S_WAIT);
  assign nWAIT    = ~(wait_req & ~CLR);
  assign dq_oe    = rd_hit & ~CLR;
  assign dq_out   = ((state_q == S_ACT) || (state_q == S_HOLD)) ? rdata_q : reg_mux;
  assign DQ       = dq_oe ? dq_out : 8'hzz;

endmodule

// File: tb/tb_z80_io_responder.sv
// Directed bench: main instance with two wait states, a second instance with
// none sharing the control strobes. DQ buses carry pull-ups so a released bus
// reads 8'hFF.
module tb_z80_io_responder;

`ifdef Z80IO_IRQ_EN
  localparam logic [7:0] IE_RB   = 8'h01;
  localparam logic [7:0] IRQ_EXP = 8'h00;
`else
  localparam logic [7:0] IE_RB   = 8'h00;
  localparam logic [7:0] IRQ_EXP = 8'h01;
`endif

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [7:0] ADDR = 8'h00;
  logic       nRD = 1'b1, nWR = 1'b1, nIORQ = 1'b1, nM1 = 1'b1;
  logic       TX_READY = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_VALID = 1'b0;
  logic       dq_en = 1'b0;
  logic [7:0] dq_val = 8'h00;

  wire  [7:0] DQ, DQ0;
  wire        nWAIT, nINT, TX_VALID, RX_READY;
  wire  [7:0] TX_DATA;
  wire        nWAIT0, nINT0, TX_VALID0, RX_READY0;
  wire  [7:0] TX_DATA0;

  int checks = 0;
  int failures = 0;
  int low0 = 0;

  always #5 CLK = ~CLK;

  assign DQ  = dq_en ? dq_val : 8'hzz;
  assign DQ0 = dq_en ? dq_val : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (DQ[g]);
    pullup (DQ0[g]);
  end

  z80_io_responder #(.BASE_ADDR(8'h10), .WAIT_STATES(2), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .CLR(CLR), .ADDR(ADDR), .DQ(DQ), .nRD(nRD), .nWR(nWR),
    .nIORQ(nIORQ), .nM1(nM1), .nWAIT(nWAIT), .nINT(nINT),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY)
  );

  z80_io_responder #(.BASE_ADDR(8'h10), .WAIT_STATES(0), .FIFO_DEPTH(4)) dut0 (
    .CLK(CLK), .CLR(CLR), .ADDR(ADDR), .DQ(DQ0), .nRD(nRD), .nWR(nWR),
    .nIORQ(nIORQ), .nM1(nM1), .nWAIT(nWAIT0), .nINT(nINT0),
    .TX_DATA(TX_DATA0), .TX_VALID(TX_VALID0), .TX_READY(1'b0),
    .RX_DATA(8'h00), .RX_VALID(1'b0), .RX_READY(RX_READY0)
  );

  // The zero-wait instance must never pull nWAIT low, even briefly.
  always @(negedge nWAIT0) low0++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One IN/OUT cycle; counts post-edge samples with nWAIT low, returns DQ in ACT.
  task automatic io(input logic rd, input logic [7:0] a, input logic [7:0] wd,
                    output logic [7:0] rdat, output int waits);
    int n;
    waits = 0;
    n     = 0;
    @(negedge CLK);
    ADDR  = a;
    nIORQ = 1'b0;
    if (rd) nRD = 1'b0;
    else begin
      nWR    = 1'b0;
      dq_val = wd;
      dq_en  = 1'b1;
    end
    do begin
      @(posedge CLK); #1;
      n++;
      if (nWAIT === 1'b0) waits++;
    end while (nWAIT !== 1'b1 && n < 20);
    chk("io_wait_release", {7'b0, nWAIT}, 8'h01);
    rdat = DQ;
    @(posedge CLK);
    @(negedge CLK);
    nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; dq_en = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic host_push(input logic [7:0] d);
    @(negedge CLK);
    RX_DATA  = d;
    RX_VALID = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    int         w;

    // Reset state while CLR is held
    #22;
    chk("rst_nWAIT", {7'b0, nWAIT}, 8'h01);
    chk("rst_nINT", {7'b0, nINT}, 8'h01);
    chk("rst_DQ_Z", DQ, 8'hFF);
    chk("rst_TX_VALID", {7'b0, TX_VALID}, 8'h00);
    chk("rst_RX_READY", {7'b0, RX_READY}, 8'h01);
    chk("rst_TX_DATA", TX_DATA, 8'h00);
    @(negedge CLK);
    CLR = 1'b0;

    // OUT (0x10),0x41 then host drains it
    io(1'b0, 8'h10, 8'h41, r, w);
    chk("wr_waits", 8'(w), 8'd2);
    chk("tx_valid", {7'b0, TX_VALID}, 8'h01);
    chk("tx_data", TX_DATA, 8'h41);
    chk("tx0_data", TX_DATA0, 8'h41);
    @(negedge CLK); TX_READY = 1'b1;
    @(negedge CLK); TX_READY = 1'b0;
    chk("tx_drained", {7'b0, TX_VALID}, 8'h00);

    // Host byte read back, then STATUS and empty DATA read
    host_push(8'h5A);
    chk("rx_ready_1", {7'b0, RX_READY}, 8'h01);
    io(1'b1, 8'h10, 8'h00, r, w);
    chk("rd_data_5A", r, 8'h5A);
    chk("rd_waits", 8'(w), 8'd2);
    io(1'b1, 8'h11, 8'h00, r, w);
    chk("status_02", r, 8'h02);
    io(1'b1, 8'h10, 8'h00, r, w);
    chk("rd_empty_00", r, 8'h00);

    // Overflow: five pushes into depth four
    for (int i = 1; i <= 5; i++) host_push(8'(i));
    chk("rx_ready_full", {7'b0, RX_READY}, 8'h00);
    io(1'b1, 8'h11, 8'h00, r, w);
    chk("status_ovf_07", r, 8'h07);
    io(1'b1, 8'h11, 8'h00, r, w);
    chk("status_clr_03", r, 8'h03);
    for (int i = 1; i <= 4; i++) begin
      io(1'b1, 8'h10, 8'h00, r, w);
      chk("rx_order", r, 8'(i));
    end
    chk("rx_ready_drained", {7'b0, RX_READY}, 8'h01);
    io(1'b1, 8'h11, 8'h00, r, w);
    chk("status_empty_02", r, 8'h02);

    // CTRL and reserved
    io(1'b0, 8'h12, 8'hFF, r, w);
    io(1'b1, 8'h12, 8'h00, r, w);
    chk("ctrl_rb", r, IE_RB);
    io(1'b1, 8'h13, 8'h00, r, w);
    chk("rsvd_FF", r, 8'hFF);
    chk("rsvd_waits", 8'(w), 8'd2);

    // Interrupt acknowledge is ignored: no drive, no wait, no pop
    host_push(8'h77);
    @(negedge CLK);
    ADDR = 8'h10; nM1 = 1'b0; nIORQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("inta_DQ_Z", DQ, 8'hFF);
      chk("inta_nWAIT", {7'b0, nWAIT}, 8'h01);
    end
    @(negedge CLK);
    nM1 = 1'b1; nIORQ = 1'b1;
    @(posedge CLK); #1;
    chk("irq_level", {7'b0, nINT}, IRQ_EXP);
    io(1'b1, 8'h10, 8'h00, r, w);
    chk("inta_no_pop", r, 8'h77);
    chk("irq_cleared", {7'b0, nINT}, 8'h01);

    // Abort during WAIT: no pop
    host_push(8'h33);
    @(negedge CLK);
    ADDR = 8'h10; nIORQ = 1'b0; nRD = 1'b0;
    @(posedge CLK); #1;
    chk("abort_in_wait", {7'b0, nWAIT}, 8'h00);
    @(negedge CLK);
    nIORQ = 1'b1; nRD = 1'b1;
    @(posedge CLK); #1;
    chk("abort_released", {7'b0, nWAIT}, 8'h01);
    io(1'b1, 8'h10, 8'h00, r, w);
    chk("abort_no_pop", r, 8'h33);

    // CLR mid-read
    host_push(8'h44);
    @(negedge CLK);
    ADDR = 8'h10; nIORQ = 1'b0; nRD = 1'b0;
    @(posedge CLK); #1;
    chk("pre_clr_nWAIT", {7'b0, nWAIT}, 8'h00);
    chk("pre_clr_DQ", DQ, 8'h44);
    #2 CLR = 1'b1;
    #1;
    chk("clr_nWAIT", {7'b0, nWAIT}, 8'h01);
    chk("clr_DQ_Z", DQ, 8'hFF);
    chk("clr_rx_ready", {7'b0, RX_READY}, 8'h01);
    @(negedge CLK);
    nIORQ = 1'b1; nRD = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    io(1'b1, 8'h11, 8'h00, r, w);
    chk("post_clr_status", r, 8'h02);
    chk("post_clr_nINT", {7'b0, nINT}, 8'h01);
    io(1'b0, 8'h10, 8'h99, r, w);
    chk("post_clr_waits", 8'(w), 8'd2);
    chk("post_clr_tx_valid", {7'b0, TX_VALID}, 8'h01);
    chk("post_clr_tx_data", TX_DATA, 8'h99);

    // Zero-wait instance
    chk("ws0_never_low", 8'(low0), 8'd0);
    chk("ws0_tx_valid", {7'b0, TX_VALID0}, 8'h01);
    chk("ws0_tx_data", TX_DATA0, 8'h99);
    chk("ws0_rx_ready", {7'b0, RX_READY0}, 8'h01);
    chk("ws0_nINT", {7'b0, nINT0}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
